// File: rtl/counter_ctrl.sv
// Prescaled up/down counter with programmable terminal value, clear/load and one-shot halt.
// Outputs are registered; tick_o pulses in the cycle the post-wrap (or held) count is shown.
module counter_ctrl #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [WIDTH-1:0]          load_value_i,
  input  logic                      up_down_i,
  input  logic                      one_shot_i,
  input  logic [WIDTH-1:0]          max_value_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [WIDTH-1:0]          counter_value_o,
  output logic                      tick_o,
  output logic                      done_o
);

  typedef enum logic {RUN, HALT} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      tick_q, tick_d;
  logic                      step;
  logic                      wrap;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
      pre_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    tick_d  = 1'b0;
    step    = 1'b0;
    wrap    = 1'b0;

    if (clear_i) begin
      cnt_d   = '0;
      pre_d   = '0;
      state_d = RUN;
    end else if (load_i) begin
      cnt_d   = load_value_i;
      pre_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN && enable_i) begin
      // >= rather than == so a prescale lowered below the running count still fires
      if (pre_q >= prescale_i) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PRESCALE_WIDTH'(1);
      end
    end

    if (step) begin
      wrap = up_down_i ? (cnt_q >= max_value_i) : (cnt_q == '0);
      if (wrap) begin
        tick_d = 1'b1;
        if (one_shot_i) begin
          state_d = HALT;
        end else begin
          cnt_d = up_down_i ? '0 : max_value_i;
        end
      end else begin
        cnt_d = up_down_i ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
      end
    end
  end

  assign counter_value_o = cnt_q;
  assign tick_o          = tick_q;
  assign done_o          = (state_q == HALT);

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: behavioural model checked every cycle on the falling edge,
// plus literal expectations at key points of each scenario.
module tb_counter_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       enable_i = 1'b0;
  logic       clear_i = 1'b0;
  logic       load_i = 1'b0;
  logic [7:0] load_value_i = '0;
  logic       up_down_i = 1'b1;
  logic       one_shot_i = 1'b0;
  logic [7:0] max_value_i = 8'd9;
  logic [7:0] prescale_i = '0;
  logic [7:0] counter_value_o;
  logic       tick_o;
  logic       done_o;

  int total = 0;
  int bad = 0;

  counter_ctrl #(.WIDTH(8), .PRESCALE_WIDTH(8)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i), .clear_i(clear_i),
    .load_i(load_i), .load_value_i(load_value_i), .up_down_i(up_down_i),
    .one_shot_i(one_shot_i), .max_value_i(max_value_i), .prescale_i(prescale_i),
    .counter_value_o(counter_value_o), .tick_o(tick_o), .done_o(done_o)
  );

  always #5 clock_i = ~clock_i;

  // Model: count, enabled cycles since last step, halted flag, tick of last edge
  int m_cnt = 0;
  int m_pre = 0;
  bit m_halt = 0;
  bit m_tick = 0;

  always @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      m_cnt = 0; m_pre = 0; m_halt = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      if (clear_i) begin
        m_cnt = 0; m_pre = 0; m_halt = 0;
      end else if (load_i) begin
        m_cnt = int'(load_value_i); m_pre = 0; m_halt = 0;
      end else if (!m_halt && enable_i) begin
        if (m_pre >= int'(prescale_i)) begin
          m_pre = 0;
          if (up_down_i ? (m_cnt >= int'(max_value_i)) : (m_cnt == 0)) begin
            m_tick = 1;
            if (one_shot_i) m_halt = 1;
            else m_cnt = up_down_i ? 0 : int'(max_value_i);
          end else begin
            m_cnt = up_down_i ? m_cnt + 1 : m_cnt - 1;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
  end

  always @(negedge clock_i) begin
    if (!reset_i) begin
      total++;
      if (int'(counter_value_o) != m_cnt) begin
        bad++;
        $display("FAIL model_count t=%0t got=%0d want=%0d", $time, counter_value_o, m_cnt);
      end
      total++;
      if (tick_o !== m_tick) begin
        bad++;
        $display("FAIL model_tick t=%0t got=%0b want=%0b", $time, tick_o, m_tick);
      end
      total++;
      if (done_o !== m_halt) begin
        bad++;
        $display("FAIL model_done t=%0t got=%0b want=%0b", $time, done_o, m_halt);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  initial begin
    #1;
    chk("reset_count", int'(counter_value_o), 0);
    chk("reset_tick", int'(tick_o), 0);
    chk("reset_done", int'(done_o), 0);
    #11 reset_i = 1'b0;

    // 1: free-running up count to 9, wrap with tick
    enable_i = 1'b1;
    step(9);
    chk("t1_count9", int'(counter_value_o), 9);
    chk("t1_tick_pre", int'(tick_o), 0);
    step(1);
    chk("t1_wrap0", int'(counter_value_o), 0);
    chk("t1_wrap_tick", int'(tick_o), 1);
    step(2);
    chk("t1_count2", int'(counter_value_o), 2);
    chk("t1_tick_off", int'(tick_o), 0);

    // 2: prescale 2 with an enable gap mid-period
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    prescale_i = 8'd2;
    step(3);
    chk("t2_first_step", int'(counter_value_o), 1);
    step(1);
    enable_i = 1'b0;
    step(5);
    chk("t2_hold", int'(counter_value_o), 1);
    enable_i = 1'b1;
    step(1);
    chk("t2_resume_wait", int'(counter_value_o), 1);
    step(1);
    chk("t2_resume_step", int'(counter_value_o), 2);

    // 2b: prescale lowered below the running prescaler count
    prescale_i = 8'd5;
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    step(4);
    prescale_i = 8'd2;
    step(1);
    chk("t2b_lowered", int'(counter_value_o), 1);

    // 3: one-shot down count from 3
    prescale_i = 8'd0; one_shot_i = 1'b1; up_down_i = 1'b0;
    load_value_i = 8'd3; load_i = 1'b1; step(1); load_i = 1'b0;
    chk("t3_load3", int'(counter_value_o), 3);
    step(3);
    chk("t3_zero", int'(counter_value_o), 0);
    chk("t3_zero_tick", int'(tick_o), 0);
    step(1);
    chk("t3_os_tick", int'(tick_o), 1);
    chk("t3_os_done", int'(done_o), 1);
    chk("t3_os_hold", int'(counter_value_o), 0);
    step(2);
    chk("t3_halt_done", int'(done_o), 1);
    chk("t3_halt_tick", int'(tick_o), 0);
    load_value_i = 8'd5; load_i = 1'b1; step(1); load_i = 1'b0;
    chk("t3_reload", int'(counter_value_o), 5);
    chk("t3_reload_done", int'(done_o), 0);
    step(1);
    chk("t3_resume", int'(counter_value_o), 4);

    // 4: clear and load on the wrap edge suppress the step
    one_shot_i = 1'b0; up_down_i = 1'b1; max_value_i = 8'd9;
    load_value_i = 8'd9; load_i = 1'b1; step(1);
    clear_i = 1'b1; load_value_i = 8'd4; step(1);
    chk("t4_clear_cnt", int'(counter_value_o), 0);
    chk("t4_clear_tick", int'(tick_o), 0);
    clear_i = 1'b0; step(1); load_i = 1'b0;
    chk("t4_load4", int'(counter_value_o), 4);

    // 5: asynchronous reset while halted at 7
    one_shot_i = 1'b1; max_value_i = 8'd7;
    load_value_i = 8'd5; load_i = 1'b1; step(1); load_i = 1'b0;
    step(2);
    chk("t5_at7", int'(counter_value_o), 7);
    step(1);
    chk("t5_done", int'(done_o), 1);
    chk("t5_held7", int'(counter_value_o), 7);
    #2 reset_i = 1'b1;
    #1;
    chk("t5_async_cnt", int'(counter_value_o), 0);
    chk("t5_async_done", int'(done_o), 0);
    #2 reset_i = 1'b0;
    one_shot_i = 1'b0; max_value_i = 8'd9; prescale_i = 8'd1;
    step(1);
    chk("t5_wait", int'(counter_value_o), 0);
    step(1);
    chk("t5_first", int'(counter_value_o), 1);

    // 6: max 0 ticks every step; load above max wraps
    prescale_i = 8'd0; max_value_i = 8'd0;
    clear_i = 1'b1; step(1); clear_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t6_max0_cnt", int'(counter_value_o), 0);
      chk("t6_max0_tick", int'(tick_o), 1);
    end
    max_value_i = 8'd10; load_value_i = 8'd200; load_i = 1'b1; step(1); load_i = 1'b0;
    chk("t6_load200", int'(counter_value_o), 200);
    chk("t6_load_tick", int'(tick_o), 0);
    step(1);
    chk("t6_over_wrap", int'(counter_value_o), 0);
    chk("t6_over_tick", int'(tick_o), 1);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
